mole_round_engine: RTL

- Game-logic stage directly downstream of the 3x3 keypad controller in the whack-a-mole design.
- Consumes the controller's valid_key level and 0-8 position code.
- Runs one round of moles: picks pseudo-random holes, times each mole's visible window, and judges key presses as hits or misses.
- Drives mole display one-hot, score and miss counters, and round status to the display/top level.

---
 rtl/mole_round_engine.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mole_round_engine.sv
`default_nettype none
// mole_round_engine: whack-a-mole round FSM (hole choice, mole timing, hit/miss judgement). Rev 1.0
// Optional macro WRONG_KEY_PENALTY_EN: a wrong-hole press in UP ends the mole as a miss.
module mole_round_engine #(
  parameter int         GAP_CYCLES  = 1000,
  parameter int         UP_CYCLES   = 5000,
  parameter int         ROUND_MOLES = 20,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       valid_key,
  input  logic [3:0] position,
  output logic [8:0] mole_onehot,
  output logic [3:0] mole_pos,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       busy,
  output logic       hit,
  output logic       round_done
);

  localparam int TMAX = (GAP_CYCLES > UP_CYCLES) ? GAP_CYCLES : UP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] UP_LAST  = TW'(UP_CYCLES - 1);
  localparam logic [7:0]    MOLES    = 8'(ROUND_MOLES);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      count_q, count_d;
  logic [3:0]      mole_pos_q, mole_pos_d;
  logic [8:0]      onehot_q, onehot_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      misses_q, misses_d;
  logic            busy_q, busy_d;
  logic            hit_q, hit_d;
  logic            done_q, done_d;
  logic [2:0]      sync_q, sync_d;

  logic            press;
  logic            wrong_key;
  logic            mole_end;
  logic [7:0]      lfsr_step;
  logic [3:0]      cand;

  assign sync_d = {sync_q[1:0], valid_key};
  assign press  = sync_q[1] & ~sync_q[2];

`ifdef WRONG_KEY_PENALTY_EN
  assign wrong_key = press && (position <= 4'd8) && (position != mole_pos_q);
`else
  assign wrong_key = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    lfsr_d     = lfsr_q;
    count_d    = count_q;
    mole_pos_d = mole_pos_q;
    onehot_d   = onehot_q;
    score_d    = score_q;
    misses_d   = misses_q;
    hit_d      = 1'b0;
    done_d     = 1'b0;
    mole_end   = 1'b0;

    // Next hole: fold the low nibble into 0-8, then bump past the previous hole.
    lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cand      = lfsr_step[3:0];
    if (cand >= 4'd9) cand = cand - 4'd9;
    if (cand == mole_pos_q) cand = (cand == 4'd8) ? 4'd0 : cand + 4'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_GAP;
          timer_d    = '0;
          lfsr_d     = LFSR_SEED;
          count_d    = 8'd0;
          mole_pos_d = 4'd0;
          score_d    = 8'd0;
          misses_d   = 8'd0;
          onehot_d   = 9'd0;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          lfsr_d     = lfsr_step;
          mole_pos_d = cand;
          onehot_d   = 9'd1 << cand;
          timer_d    = '0;
          state_d    = S_UP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_UP: begin
        // A correct press wins over a same-cycle expiry.
        if (press && (position == mole_pos_q)) begin
          hit_d    = 1'b1;
          score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          mole_end = 1'b1;
        end else if ((timer_q == UP_LAST) || wrong_key) begin
          misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
          mole_end = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        if (mole_end) begin
          onehot_d = 9'd0;
          count_d  = count_q + 8'd1;
          timer_d  = '0;
          if (count_q + 8'd1 == MOLES) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_GAP) || (state_d == S_UP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      count_q    <= 8'd0;
      mole_pos_q <= 4'd0;
      onehot_q   <= 9'd0;
      score_q    <= 8'd0;
      misses_q   <= 8'd0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
      sync_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lfsr_q     <= lfsr_d;
      count_q    <= count_d;
      mole_pos_q <= mole_pos_d;
      onehot_q   <= onehot_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
      done_q     <= done_d;
      sync_q     <= sync_d;
    end
  end

  assign mole_onehot = onehot_q;
  assign mole_pos    = mole_pos_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign busy        = busy_q;
  assign hit         = hit_q;
  assign round_done  = done_q;

endmodule
`default_nettype wire
